// File: rtl/serializator_produs_if.sv
// serializator_produs_if
//   Bundles the product input channel and the ALU result channel.
//   Input side : in_valid/in_ready handshake carrying the 64-bit produs_in.
//   Output side: out_valid/out_ready handshake carrying 32-bit out_data beats,
//                tagged with out_hi (word select) and out_last (final beat).
//   count      : FIFO occupancy, reported by the serializer.
//   Modports   : slave  - the serializer (consumes products, drives beats)
//                master - the environment (multiplier + result consumer)
interface serializator_produs_if #(
    parameter int PTR_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      produs_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_hi;
    logic             out_last;
    logic [PTR_W:0]   count;

    modport slave (
        input  in_valid, produs_in, out_ready,
        output in_ready, out_valid, out_data, out_hi, out_last, count
    );

    modport master (
        output in_valid, produs_in, out_ready,
        input  in_ready, out_valid, out_data, out_hi, out_last, count
    );
endinterface

// File: rtl/serializator_produs.sv
// serializator_produs
//   Buffers 64-bit products from the multiplier in a DEPTH-entry FIFO and
//   emits each one on the 32-bit result bus as a low-word beat followed by a
//   high-word beat. Storage is registered: nothing falls through in the cycle
//   of the push, and a pop frees in_ready only in the following cycle.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset; drops all buffered products
//     bus  - serializator_produs_if.slave (input/output handshakes, count)
//   Parameters:
//     DEPTH - entries, power of 2 (>= 2); PTR_W - log2(DEPTH)
//   Optional build macro SERIALIZATOR_ZERO_SKIP_EN: products whose high word
//     is zero are sent as a single low beat with out_last=1.
module serializator_produs #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    serializator_produs_if.slave  bus
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    // Beat phase of the head entry: low word first, then high word.
    typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_e;

    phase_e           phase_q, phase_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [63:0]      mem [DEPTH];

    logic        push, beat, pop, non_empty, skip_hi;
    logic [63:0] head;

    assign head      = mem[rd_ptr_q];
    assign non_empty = (count_q != '0);

`ifdef SERIALIZATOR_ZERO_SKIP_EN
    // A zero high word makes the low beat the last one.
    assign skip_hi = (phase_q == PH_LO) && (head[63:32] == 32'h0);
`else
    assign skip_hi = 1'b0;
`endif

    assign bus.in_ready = !rst && (count_q != FULL);
    assign push = bus.in_valid && bus.in_ready;
    assign beat = non_empty && bus.out_ready;
    assign pop  = beat && ((phase_q == PH_HI) || skip_hi);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_LO;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.produs_in;
    end

    // Next-state logic
    always_comb begin
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (beat) phase_d = pop ? PH_LO : PH_HI;
        // Pointers are exactly PTR_W wide, so increment wraps modulo DEPTH.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Output logic: depends on registered state only, so it holds during stalls.
    always_comb begin
        bus.out_valid = non_empty;
        bus.out_hi    = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = 32'h0;
        bus.count     = count_q;
        if (non_empty) begin
            bus.out_hi   = (phase_q == PH_HI);
            bus.out_last = (phase_q == PH_HI) || skip_hi;
            bus.out_data = (phase_q == PH_HI) ? head[63:32] : head[31:0];
        end
    end
endmodule

// File: tb/tb_serializator_produs.sv
// tb_serializator_produs
//   Directed bench for serializator_produs (DEPTH=4). Inputs change 1 ns after
//   the rising edge; outputs are sampled at that point, since they depend only
//   on registered state (and on rst for in_ready).
module tb_serializator_produs;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serializator_produs_if #(.PTR_W(PTR_W)) bus ();
    serializator_produs #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // {valid, hi, last, data}
    logic [34:0] obs;
    assign obs = {bus.out_valid, bus.out_hi, bus.out_last, bus.out_data};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.produs_in = '0;
        tick(); tick();
        checks++;
        if ({obs, bus.count, bus.in_ready} !== '0) begin
            errors++; $display("FAIL reset_state: got obs=%h count=%0d in_ready=%0b, want all 0", obs, bus.count, bus.in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        bus.produs_in = 64'h0000_0003_0000_0005; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick(); bus.in_valid = 1'b0;
        checks++;
        if ({obs, bus.count} !== {3'b100, 32'h5, 3'd1}) begin
            errors++; $display("FAIL single_lo: got obs=%h count=%0d want obs=%h count=1", obs, bus.count, {3'b100, 32'h5});
        end
        tick();
        checks++;
        if (obs !== {3'b111, 32'h3}) begin
            errors++; $display("FAIL single_hi: got %h want %h", obs, {3'b111, 32'h3});
        end
        tick();
        checks++;
        if ({obs, bus.count} !== '0) begin
            errors++; $display("FAIL single_empty: got obs=%h count=%0d want 0", obs, bus.count);
        end
    endtask

    task automatic test_fill();
        logic [34:0] exp;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.produs_in = 64'(i); bus.in_valid = 1'b1;
            tick();
        end
        checks++;
        if ({bus.count, bus.in_ready} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL fill_full: got count=%0d in_ready=%0b want 4/0", bus.count, bus.in_ready);
        end
        bus.produs_in = 64'hFFFF;
        tick(); bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 3'd4) begin
            errors++; $display("FAIL fill_overflow_ignored: got count=%0d want 4", bus.count);
        end
        bus.out_ready = 1'b1;
`ifdef SERIALIZATOR_ZERO_SKIP_EN
        for (int k = 0; k < 4; k++) begin
            exp = {3'b101, 32'(k + 1)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL fill_drain_beat%0d: got %h want %h", k, obs, exp);
            end
            tick();
        end
`else
        for (int k = 0; k < 8; k++) begin
            exp = (k % 2 == 1) ? {3'b111, 32'h0} : {3'b100, 32'(k / 2 + 1)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL fill_drain_beat%0d: got %h want %h", k, obs, exp);
            end
            tick();
        end
`endif
        checks++;
        if ({obs, bus.count} !== '0) begin
            errors++; $display("FAIL fill_drained: got obs=%h count=%0d want 0", obs, bus.count);
        end
        bus.out_ready = 1'b0;
    endtask

    // Full FIFO, both sides streaming; a small queue model tracks order and
    // occupancy over 10 products (wraps the pointers twice).
    task automatic test_back_to_back();
        logic [63:0] q[$];
        logic        ph;
        logic        exp_ready, do_push, do_pop;
        logic [34:0] exp;
        int          nxt, popped;
        ph = 1'b0; popped = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.produs_in = {32'(i + 100), 32'(i)}; bus.in_valid = 1'b1;
            tick();
            q.push_back({32'(i + 100), 32'(i)});
        end
        nxt = 4;
        bus.out_ready = 1'b1; bus.produs_in = {32'(nxt + 100), 32'(nxt)};
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            exp_ready = (q.size() != DEPTH);
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++; $display("FAIL b2b_in_ready cyc%0d: got %0b want %0b", cyc, bus.in_ready, exp_ready);
            end
            if (q.size() != 0) exp = {1'b1, ph, ph, ph ? q[0][63:32] : q[0][31:0]};
            else               exp = '0;
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b_beat cyc%0d: got %h want %h", cyc, obs, exp);
            end
            do_push = bus.in_valid && exp_ready;
            do_pop  = (q.size() != 0) && ph;
            if (q.size() != 0) ph = ~ph;
            if (do_pop) begin void'(q.pop_front()); popped++; end
            if (do_push) begin q.push_back({32'(nxt + 100), 32'(nxt)}); nxt++; end
            tick();
            bus.in_valid  = (nxt < 10);
            bus.produs_in = {32'(nxt + 100), 32'(nxt)};
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++;
        if (popped != 10 || bus.count !== '0) begin
            errors++; $display("FAIL b2b_complete: got popped=%0d count=%0d want 10/0", popped, bus.count);
        end
    endtask

    task automatic test_stall();
        bus.produs_in = 64'hDEAD_BEEF_1234_5678; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick(); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (obs !== {3'b100, 32'h1234_5678}) begin
                errors++; $display("FAIL stall_lo%0d: got %h want %h", s, obs, {3'b100, 32'h1234_5678});
            end
            if (s < 2) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (obs !== {3'b111, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL stall_hi: got %h want %h", obs, {3'b111, 32'hDEAD_BEEF});
        end
        tick();
        checks++;
        if ({obs, bus.count} !== '0) begin
            errors++; $display("FAIL stall_empty: got obs=%h count=%0d want 0", obs, bus.count);
        end
    endtask

    task automatic test_reset_mid();
        bus.produs_in = 64'h0000_000A_0000_000B; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick(); bus.in_valid = 1'b0;
        checks++;
        if (obs !== {3'b100, 32'hB}) begin
            errors++; $display("FAIL rstmid_lo: got %h want %h", obs, {3'b100, 32'hB});
        end
        tick();
        checks++;
        if (obs !== {3'b111, 32'hA}) begin
            errors++; $display("FAIL rstmid_hi_pending: got %h want %h", obs, {3'b111, 32'hA});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({obs, bus.count, bus.in_ready} !== '0) begin
            errors++; $display("FAIL rstmid_async: got obs=%h count=%0d in_ready=%0b want 0", obs, bus.count, bus.in_ready);
        end
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({obs, bus.count} !== '0) begin
                errors++; $display("FAIL rstmid_no_beat%0d: got obs=%h count=%0d want 0", c, obs, bus.count);
            end
        end
        bus.produs_in = 64'h0000_0001_0000_0002; bus.in_valid = 1'b1;
        tick(); bus.in_valid = 1'b0;
        checks++;
        if (obs !== {3'b100, 32'h2}) begin
            errors++; $display("FAIL rstmid_next_lo: got %h want %h", obs, {3'b100, 32'h2});
        end
        tick();
        checks++;
        if (obs !== {3'b111, 32'h1}) begin
            errors++; $display("FAIL rstmid_next_hi: got %h want %h", obs, {3'b111, 32'h1});
        end
        tick();
    endtask

    task automatic test_zero_skip();
        bus.produs_in = 64'h7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick(); bus.in_valid = 1'b0;
`ifdef SERIALIZATOR_ZERO_SKIP_EN
        checks++;
        if (obs !== {3'b101, 32'h7}) begin
            errors++; $display("FAIL zskip_single: got %h want %h", obs, {3'b101, 32'h7});
        end
`else
        checks++;
        if (obs !== {3'b100, 32'h7}) begin
            errors++; $display("FAIL zskip_lo: got %h want %h", obs, {3'b100, 32'h7});
        end
        tick();
        checks++;
        if (obs !== {3'b111, 32'h0}) begin
            errors++; $display("FAIL zskip_hi: got %h want %h", obs, {3'b111, 32'h0});
        end
`endif
        tick();
        checks++;
        if ({obs, bus.count} !== '0) begin
            errors++; $display("FAIL zskip_empty: got obs=%h count=%0d want 0", obs, bus.count);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_zero_skip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
